// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access size encodings, FSM states, counter width.
// Size encoding matches the pipeline's MemRead/MemWrite fields.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_NONE = 2'b00,
    SIZE_WORD = 2'b01,
    SIZE_HALF = 2'b10,
    SIZE_BYTE = 2'b11
  } memSizeE;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } stateE;

  // Counter holds at most LATENCY-1, and LATENCY tops out at 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic shared by loads and stores: error check, write mask/data, load extract.
// Zero latency; no flow control, purely a function of size/addr/data.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic        isUnsigned,
  input  logic [31:0] wData,
  input  logic [31:0] rdWord,
  output logic        err,
  output logic [3:0]  byteMask,
  output logic [31:0] wrWord,
  output logic [31:0] rdData
);

  logic        outOfRange;
  logic [15:0] halfSel;
  logic [7:0]  byteSel;

  always_comb begin
    outOfRange = {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS);
    halfSel    = addr[1] ? rdWord[31:16] : rdWord[15:0];
    byteSel    = addr[0] ? halfSel[15:8] : halfSel[7:0];

    err      = 1'b0;
    byteMask = 4'b0000;
    wrWord   = '0;
    rdData   = '0;

    // Narrow store data is replicated across lanes; the mask picks the live ones.
    case (size)
      SIZE_WORD: begin
        err      = addr[1:0] != 2'b00;
        byteMask = 4'b1111;
        wrWord   = wData;
        rdData   = rdWord;
      end
      SIZE_HALF: begin
        err      = addr[0];
        byteMask = addr[1] ? 4'b1100 : 4'b0011;
        wrWord   = {2{wData[15:0]}};
        rdData   = {{16{~isUnsigned & halfSel[15]}}, halfSel};
      end
      SIZE_BYTE: begin
        err      = 1'b0;
        byteMask = 4'b0001 << addr[1:0];
        wrWord   = {4{wData[7:0]}};
        rdData   = {{24{~isUnsigned & byteSel[7]}}, byteSel};
      end
      default: err = 1'b1;
    endcase

    err = err | outOfRange;
    if (err) begin
      byteMask = 4'b0000;
      rdData   = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory with fixed LATENCY from accept to a one-cycle response pulse.
// One request in flight; ReqReady low from accept through the response, no response backpressure.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqUnsigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspError
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  stateE             state;
  stateE             stateNext;
  logic [CNT_W-1:0]  cnt;
  logic              accept;

  logic              heldWrite;
  logic [1:0]        heldSize;
  logic              heldUnsigned;
  logic [31:0]       heldAddr;
  logic [31:0]       heldWData;

  logic [IDX_W-1:0]  wordIdx;
  logic [31:0]       rdWord;
  logic              laneErr;
  logic [3:0]        byteMask;
  logic [31:0]       wrWord;
  logic [31:0]       laneRd;

  logic [31:0]       storage [DEPTH_WORDS] = '{default: '0};

  assign accept  = (state == IDLE) && ReqValid;
  assign wordIdx = heldAddr[2 +: IDX_W];
  assign rdWord  = storage[wordIdx];

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (ReqValid) stateNext = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ReqReady = (state == IDLE);
    RspValid = (state == RESP);
    RspError = (state == RESP) && laneErr;
    RspData  = (state == RESP && !heldWrite) ? laneRd : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset)              cnt <= '0;
    else if (accept)        cnt <= CNT_W'(LATENCY - 1);
    else if (state == WAIT) cnt <= cnt - CNT_W'(1);
    else                    cnt <= '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      heldWrite    <= 1'b0;
      heldSize     <= SIZE_NONE;
      heldUnsigned <= 1'b0;
      heldAddr     <= '0;
      heldWData    <= '0;
    end else if (accept) begin
      heldWrite    <= ReqWrite;
      heldSize     <= ReqSize;
      heldUnsigned <= ReqUnsigned;
      heldAddr     <= ReqAddr;
      heldWData    <= ReqWData;
    end
  end

  dmem_lane_align #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_lane (
    .size      (heldSize),
    .addr      (heldAddr),
    .isUnsigned(heldUnsigned),
    .wData     (heldWData),
    .rdWord    (rdWord),
    .err       (laneErr),
    .byteMask  (byteMask),
    .wrWord    (wrWord),
    .rdData    (laneRd)
  );

  // Store commits on the edge that ends RESP; an error leaves byteMask empty.
  always_ff @(posedge Clk) begin
    if (!Reset && state == RESP && heldWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteMask[b]) storage[wordIdx][8*b +: 8] <= wrWord[8*b +: 8];
      end
    end
  end

endmodule
